// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-read-port register file with write-first bypass and pending scoreboard
// Optional: define REG_FILE_ZERO_REG_EN to hardwire register 0 to zero.
module reg_file_mp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NREAD  = 2
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      WRITE,
  input  logic [ADDR_W-1:0]         INADDRESS,
  input  logic [DATA_W-1:0]         IN,
  input  logic                      SET_PEND,
  input  logic [ADDR_W-1:0]         PENDADDRESS,
  input  logic [NREAD*ADDR_W-1:0]   OUTADDRESS,
  output logic [NREAD*DATA_W-1:0]   OUT,
  output logic [NREAD-1:0]          OUTPEND,
  output logic                      ANYPEND
);

  localparam int DEPTH = 1 << ADDR_W;

`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [DATA_W-1:0]       regs_q [DEPTH];
  logic [DATA_W-1:0]       regs_d [DEPTH];
  logic [DEPTH-1:0]        pend_q, pend_d;
  logic [NREAD*DATA_W-1:0] out_q, out_d;
  logic [NREAD-1:0]        outpend_q, outpend_d;
  logic                    anypend_q, anypend_d;
  logic                    wr_en, set_en;

  // With the zero register enabled, r0 simply never accepts a write or a set.
  assign wr_en  = WRITE    && !(ZERO_REG && (INADDRESS == '0));
  assign set_en = SET_PEND && !(ZERO_REG && (PENDADDRESS == '0));

  // Reads see the post-edge state, which gives write-first bypass and set-wins for free.
  always_comb begin
    regs_d    = regs_q;
    pend_d    = pend_q;
    out_d     = '0;
    outpend_d = '0;
    if (wr_en) begin
      regs_d[INADDRESS] = IN;
      pend_d[INADDRESS] = 1'b0;
    end
    if (set_en) begin
      pend_d[PENDADDRESS] = 1'b1;
    end
    for (int k = 0; k < NREAD; k++) begin
      out_d[k*DATA_W +: DATA_W] = regs_d[OUTADDRESS[k*ADDR_W +: ADDR_W]];
      outpend_d[k]              = pend_d[OUTADDRESS[k*ADDR_W +: ADDR_W]];
    end
    anypend_d = |pend_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      pend_q    <= '0;
      out_q     <= '0;
      outpend_q <= '0;
      anypend_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pend_q    <= pend_d;
      out_q     <= out_d;
      outpend_q <= outpend_d;
      anypend_q <= anypend_d;
    end
  end

  assign OUT     = out_q;
  assign OUTPEND = outpend_q;
  assign ANYPEND = anypend_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed vector table plus randomized model check for reg_file_mp
module tb_reg_file_mp;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int NREAD  = 2;
  localparam int DEPTH  = 1 << ADDR_W;

`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic                    CLK = 1'b0;
  logic                    RESET;
  logic                    WRITE;
  logic [ADDR_W-1:0]       INADDRESS;
  logic [DATA_W-1:0]       IN;
  logic                    SET_PEND;
  logic [ADDR_W-1:0]       PENDADDRESS;
  logic [NREAD*ADDR_W-1:0] OUTADDRESS;
  logic [NREAD*DATA_W-1:0] OUT;
  logic [NREAD-1:0]        OUTPEND;
  logic                    ANYPEND;

  reg_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD)) dut (
    .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
    .SET_PEND(SET_PEND), .PENDADDRESS(PENDADDRESS), .OUTADDRESS(OUTADDRESS),
    .OUT(OUT), .OUTPEND(OUTPEND), .ANYPEND(ANYPEND)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       wr;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic       setp;
    logic [2:0] paddr;
    logic [2:0] ra0;
    logic [2:0] ra1;
    logic [7:0] eo0;
    logic [7:0] eo1;
    logic       ep0;
    logic       ep1;
    logic       eany;
  } vec_t;

  vec_t vecs[12];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0] mem [DEPTH];
  logic       pend [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic wr, input logic [2:0] wa, input logic [7:0] wd,
                       input logic sp, input logic [2:0] pa, input logic [2:0] r0, input logic [2:0] r1);
    @(negedge CLK);
    RESET = rst; WRITE = wr; INADDRESS = wa; IN = wd;
    SET_PEND = sp; PENDADDRESS = pa; OUTADDRESS = {r1, r0};
    @(posedge CLK);
    #1;
  endtask

  task automatic compare_all(input string tag, input logic [7:0] eo0, input logic [7:0] eo1,
                             input logic ep0, input logic ep1, input logic eany);
    check({tag, ".out0"}, 32'(OUT[7:0]), 32'(eo0));
    check({tag, ".out1"}, 32'(OUT[15:8]), 32'(eo1));
    check({tag, ".pend0"}, 32'(OUTPEND[0]), 32'(ep0));
    check({tag, ".pend1"}, 32'(OUTPEND[1]), 32'(ep1));
    check({tag, ".anypend"}, 32'(ANYPEND), 32'(eany));
  endtask

  // Reference: registers and pending bits as plain arrays, rules applied in spec order.
  task automatic model_step(input logic rst, input logic wr, input logic [2:0] wa, input logic [7:0] wd,
                            input logic sp, input logic [2:0] pa);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin mem[i] = 8'h00; pend[i] = 1'b0; end
      return;
    end
    if (wr && !(ZERO && wa == 3'd0)) begin mem[wa] = wd; pend[wa] = 1'b0; end
    if (sp && !(ZERO && pa == 3'd0)) pend[pa] = 1'b1;
  endtask

  function automatic logic model_any();
    logic a = 1'b0;
    for (int i = 0; i < DEPTH; i++) a |= pend[i];
    return a;
  endfunction

  initial begin
    RESET = 1'b1; WRITE = 1'b0; INADDRESS = '0; IN = '0;
    SET_PEND = 1'b0; PENDADDRESS = '0; OUTADDRESS = '0;

    //          rst wr  wa    wd     sp  pa    ra0   ra1   eo0    eo1    ep0 ep1 any
    vecs[0]  = '{0, 1, 3'd3, 8'hAA, 0, 3'd0, 3'd3, 3'd3, 8'hAA, 8'hAA, 0, 0, 0};
    vecs[1]  = '{1, 1, 3'd3, 8'h55, 1, 3'd1, 3'd3, 3'd3, 8'h00, 8'h00, 0, 0, 0};
    vecs[2]  = '{0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd3, 3'd3, 8'h00, 8'h00, 0, 0, 0};
    vecs[3]  = '{0, 1, 3'd5, 8'h5C, 0, 3'd0, 3'd1, 3'd1, 8'h00, 8'h00, 0, 0, 0};
    vecs[4]  = '{0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 3'd5, 8'h00, 8'h5C, 0, 0, 0};
    vecs[5]  = '{0, 1, 3'd2, 8'h3F, 0, 3'd0, 3'd2, 3'd5, 8'h3F, 8'h5C, 0, 0, 0};
    vecs[6]  = '{0, 0, 3'd0, 8'h00, 1, 3'd4, 3'd2, 3'd2, 8'h3F, 8'h3F, 0, 0, 1};
    vecs[7]  = '{0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd4, 3'd4, 8'h00, 8'h00, 1, 1, 1};
    vecs[8]  = '{0, 1, 3'd4, 8'h11, 0, 3'd0, 3'd4, 3'd4, 8'h11, 8'h11, 0, 0, 0};
    vecs[9]  = '{0, 1, 3'd6, 8'h77, 1, 3'd6, 3'd6, 3'd6, 8'h77, 8'h77, 1, 1, 1};
`ifdef REG_FILE_ZERO_REG_EN
    vecs[10] = '{0, 1, 3'd0, 8'hFF, 1, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 0, 0, 1};
    vecs[11] = '{0, 1, 3'd6, 8'h01, 0, 3'd0, 3'd0, 3'd6, 8'h00, 8'h01, 0, 0, 0};
`else
    vecs[10] = '{0, 1, 3'd0, 8'hFF, 1, 3'd0, 3'd0, 3'd0, 8'hFF, 8'hFF, 1, 1, 1};
    vecs[11] = '{0, 1, 3'd6, 8'h01, 0, 3'd0, 3'd0, 3'd6, 8'hFF, 8'h01, 1, 0, 1};
`endif

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    compare_all("reset_state", 8'h00, 8'h00, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst, vecs[i].wr, vecs[i].waddr, vecs[i].wdata,
            vecs[i].setp, vecs[i].paddr, vecs[i].ra0, vecs[i].ra1);
      compare_all($sformatf("vec%0d", i), vecs[i].eo0, vecs[i].eo1,
                  vecs[i].ep0, vecs[i].ep1, vecs[i].eany);
    end

    // Hand sequence: reset overrides a pending write that targets a pending register.
    drive(0, 0, 0, 0, 1, 3'd7, 3'd7, 3'd7);
    compare_all("set_r7", 8'h00, 8'h00, 1, 1, 1);
    drive(1, 1, 3'd7, 8'hC3, 1, 3'd7, 3'd7, 3'd7);
    compare_all("reset_override", 8'h00, 8'h00, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 3'd7, 3'd6);
    compare_all("after_reset", 8'h00, 8'h00, 0, 0, 0);

    model_step(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      logic       rst, wr, sp;
      logic [2:0] wa, pa, r0, r1;
      logic [7:0] wd;
      rst = ($urandom_range(0, 39) == 0);
      wr  = $urandom_range(0, 1) != 0;
      sp  = ($urandom_range(0, 2) == 0);
      wa  = 3'($urandom_range(0, 7));
      pa  = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      r0  = ($urandom_range(0, 2) == 0) ? wa : 3'($urandom_range(0, 7));
      r1  = ($urandom_range(0, 3) == 0) ? r0 : 3'($urandom_range(0, 7));
      wd  = 8'($urandom);
      drive(rst, wr, wa, wd, sp, pa, r0, r1);
      model_step(rst, wr, wa, wd, sp, pa);
      if (rst)
        compare_all($sformatf("rnd%0d", n), 8'h00, 8'h00, 0, 0, 0);
      else
        compare_all($sformatf("rnd%0d", n), mem[r0], mem[r1], pend[r0], pend[r1], model_any());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
